// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-requester bus arbiter.
// Contents:
//   arb_state_e  - arbiter FSM states (IDLE, GRANT_1, GRANT_2)
//   SRC_1/SRC_2  - source ids, encoded to match the mux select (0 = source 1)
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_1 = 2'd1,
    GRANT_2 = 2'd2
  } arb_state_e;

  localparam logic SRC_1 = 1'b0;
  localparam logic SRC_2 = 1'b1;

endpackage

// File: rtl/arb_hold_cnt.sv
// Grant hold counter: counts cycles spent in the current grant and saturates
// at HOLD_MAX-1, which marks the point where a waiting requester must be served.
// Parameters:
//   HOLD_MAX - maximum consecutive grant cycles (>= 1)
// Ports:
//   clk     in  - clock, rising edge
//   rst     in  - synchronous active-high reset
//   clear   in  - restart the count at 0 (entry into a grant); wins over en
//   en      in  - count this cycle (arbiter is in a grant state)
//   expired out - counter is saturated at HOLD_MAX-1
module arb_hold_cnt #(
  parameter int HOLD_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [W-1:0] SAT = W'(HOLD_MAX - 1);

  logic [W-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && (cnt != SAT)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (cnt == SAT);

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter driving the select of a 4-bit 2:1 bus mux.
// A grant is held for at most HOLD_MAX cycles while the other side waits; an
// idle tie goes to the source that was not served last. All outputs are flops.
// Optional feature: define BUS_ARB_LOCK_EN to add lock_1/lock_2, which let the
// current owner keep the bus past hold expiry while it keeps requesting.
// Parameters:
//   HOLD_MAX  - maximum consecutive grant cycles (>= 1)
// Ports:
//   clk       in  - clock, rising edge
//   rst       in  - synchronous active-high reset
//   req_1     in  - source 1 requests the bus (level)
//   req_2     in  - source 2 requests the bus (level)
//   lock_1    in  - (BUS_ARB_LOCK_EN only) source 1 refuses hold expiry
//   lock_2    in  - (BUS_ARB_LOCK_EN only) source 2 refuses hold expiry
//   gnt_1     out - source 1 owns the bus this cycle
//   gnt_2     out - source 2 owns the bus this cycle
//   sel       out - mux select, 0 = source 1, 1 = source 2; held while idle
//   bus_valid out - mux output carries granted data
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_1,
  input  logic req_2,
`ifdef BUS_ARB_LOCK_EN
  input  logic lock_1,
  input  logic lock_2,
`endif
  output logic gnt_1,
  output logic gnt_2,
  output logic sel,
  output logic bus_valid
);

  arb_state_e state, next_state;
  logic       last;
  logic       expired;
  logic       hold_1, hold_2;
  logic       cnt_clear, cnt_en;

  // Owner lock only matters while that owner is still requesting, which the
  // next-state logic already checks before looking at expiry.
`ifdef BUS_ARB_LOCK_EN
  assign hold_1 = lock_1;
  assign hold_2 = lock_2;
`else
  assign hold_1 = 1'b0;
  assign hold_2 = 1'b0;
`endif

  // NOTE: every variable driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req_1 && req_2) begin
          next_state = (last == SRC_1) ? GRANT_2 : GRANT_1;
        end else if (req_1) begin
          next_state = GRANT_1;
        end else if (req_2) begin
          next_state = GRANT_2;
        end
      end
      GRANT_1: begin
        if (!req_1) begin
          next_state = req_2 ? GRANT_2 : IDLE;
        end else if (expired && req_2 && !hold_1) begin
          next_state = GRANT_2;
        end
      end
      GRANT_2: begin
        if (!req_2) begin
          next_state = req_1 ? GRANT_1 : IDLE;
        end else if (expired && req_1 && !hold_2) begin
          next_state = GRANT_1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A new grant (from IDLE or a handover) restarts the hold count.
  assign cnt_clear = (next_state != state) && (next_state != IDLE);
  assign cnt_en    = (state != IDLE);

  arb_hold_cnt #(
    .HOLD_MAX (HOLD_MAX)
  ) u_hold_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .en      (cnt_en),
    .expired (expired)
  );

  // Outputs are decoded from next_state into flops so they line up with the
  // state register and the mux select cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= SRC_2;
      gnt_1     <= 1'b0;
      gnt_2     <= 1'b0;
      sel       <= SRC_1;
      bus_valid <= 1'b0;
    end else begin
      state     <= next_state;
      gnt_1     <= (next_state == GRANT_1);
      gnt_2     <= (next_state == GRANT_2);
      bus_valid <= (next_state != IDLE);
      if (next_state == GRANT_1) begin
        sel <= SRC_1;
      end else if (next_state == GRANT_2) begin
        sel <= SRC_2;
      end
      if (cnt_clear) begin
        last <= (next_state == GRANT_2) ? SRC_2 : SRC_1;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter. Three instances share the
// request/reset stimulus: HOLD_MAX=4 (main), HOLD_MAX=1 and HOLD_MAX=2 (the
// latter also exercises the lock ports when BUS_ARB_LOCK_EN is defined).
// Outputs are packed as {gnt_1, gnt_2, sel, bus_valid} for comparison.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic req_1, req_2;
  logic lock_1, lock_2;

  logic g1_4, g2_4, sel_4, val_4;
  logic g1_1, g2_1, sel_1, val_1;
  logic g1_2, g2_2, sel_2, val_2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.HOLD_MAX(4)) u_h4 (
    .clk(clk), .rst(rst), .req_1(req_1), .req_2(req_2),
`ifdef BUS_ARB_LOCK_EN
    .lock_1(1'b0), .lock_2(1'b0),
`endif
    .gnt_1(g1_4), .gnt_2(g2_4), .sel(sel_4), .bus_valid(val_4)
  );

  bus_arbiter #(.HOLD_MAX(1)) u_h1 (
    .clk(clk), .rst(rst), .req_1(req_1), .req_2(req_2),
`ifdef BUS_ARB_LOCK_EN
    .lock_1(1'b0), .lock_2(1'b0),
`endif
    .gnt_1(g1_1), .gnt_2(g2_1), .sel(sel_1), .bus_valid(val_1)
  );

  bus_arbiter #(.HOLD_MAX(2)) u_h2 (
    .clk(clk), .rst(rst), .req_1(req_1), .req_2(req_2),
`ifdef BUS_ARB_LOCK_EN
    .lock_1(lock_1), .lock_2(lock_2),
`endif
    .gnt_1(g1_2), .gnt_2(g2_2), .sel(sel_2), .bus_valid(val_2)
  );

  localparam logic [3:0] OUT_IDLE0 = 4'b0000; // idle, sel=0
  localparam logic [3:0] OUT_IDLE1 = 4'b0010; // idle, sel=1
  localparam logic [3:0] OUT_G1    = 4'b1001; // gnt_1, sel=0, valid
  localparam logic [3:0] OUT_G2    = 4'b0111; // gnt_2, sel=1, valid

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Hand-computed grant owners after each edge with both requesting.
    int fair_4 [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};
    int fair_2 [12] = '{1, 1, 2, 2, 1, 1, 2, 2, 1, 1, 2, 2};
    int fair_1 [12] = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2};

    rst = 1'b1; req_1 = 1'b1; req_2 = 1'b1; lock_1 = 1'b0; lock_2 = 1'b0;

    // Reset held for 3 cycles with both requesting: everything stays clear.
    step(); step(); step();
    check("reset_h4", {g1_4, g2_4, sel_4, val_4}, OUT_IDLE0);
    check("reset_h1", {g1_1, g2_1, sel_1, val_1}, OUT_IDLE0);

    // Release reset; both keep requesting. First grant goes to source 1.
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("fair_h4_%0d", i + 1), {g1_4, g2_4, sel_4, val_4},
            (fair_4[i] == 1) ? OUT_G1 : OUT_G2);
      check($sformatf("fair_h2_%0d", i + 1), {g1_2, g2_2, sel_2, val_2},
            (fair_2[i] == 1) ? OUT_G1 : OUT_G2);
      check($sformatf("fair_h1_%0d", i + 1), {g1_1, g2_1, sel_1, val_1},
            (fair_1[i] == 1) ? OUT_G1 : OUT_G2);
    end

    // Reset asserted mid-grant clears outputs after the next edge.
    rst = 1'b1;
    step();
    check("rst_mid_h4", {g1_4, g2_4, sel_4, val_4}, OUT_IDLE0);

    // Early release: source 1 granted, drops at its 2nd cycle while source 2
    // waits; handover happens on a single edge.
    rst = 1'b0; req_1 = 1'b1; req_2 = 1'b0;
    step();
    check("early_g1", {g1_4, g2_4, sel_4, val_4}, OUT_G1);
    step();
    check("early_g1_c2", {g1_4, g2_4, sel_4, val_4}, OUT_G1);
    req_1 = 1'b0; req_2 = 1'b1;
    step();
    check("early_handover", {g1_4, g2_4, sel_4, val_4}, OUT_G2);

    // Single requester on source 2 for 10 more cycles: never switches.
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("single_g2_%0d", i + 1), {g1_4, g2_4, sel_4, val_4}, OUT_G2);
    end

    // Drop request: idle next edge, sel stays on source 2.
    req_2 = 1'b0;
    step();
    check("single_idle", {g1_4, g2_4, sel_4, val_4}, OUT_IDLE1);
    step();
    check("single_idle_hold", {g1_4, g2_4, sel_4, val_4}, OUT_IDLE1);

    // Idle tie with last = source 2 goes to source 1.
    req_1 = 1'b1; req_2 = 1'b1;
    step();
    check("tie_last2", {g1_4, g2_4, sel_4, val_4}, OUT_G1);

    // Idle, then tie with last = source 1 goes to source 2.
    req_1 = 1'b0; req_2 = 1'b0;
    step();
    check("tie_idle", {g1_4, g2_4, sel_4, val_4}, OUT_IDLE0);
    req_1 = 1'b1; req_2 = 1'b1;
    step();
    check("tie_last1", {g1_4, g2_4, sel_4, val_4}, OUT_G2);

`ifdef BUS_ARB_LOCK_EN
    // Lock on the HOLD_MAX=2 instance.
    rst = 1'b1; req_1 = 1'b0; req_2 = 1'b0;
    step();
    check("lock_rst", {g1_2, g2_2, sel_2, val_2}, OUT_IDLE0);
    rst = 1'b0; req_1 = 1'b1; lock_1 = 1'b1; req_2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("lock_g1_%0d", i + 1), {g1_2, g2_2, sel_2, val_2}, OUT_G1);
    end
    lock_1 = 1'b0;
    step();
    check("unlock_switch", {g1_2, g2_2, sel_2, val_2}, OUT_G2);
    lock_2 = 1'b1;
    step(); step(); step();
    check("lock_g2", {g1_2, g2_2, sel_2, val_2}, OUT_G2);
    rst = 1'b1;
    step();
    check("lock_rst_mid", {g1_2, g2_2, sel_2, val_2}, OUT_IDLE0);
    rst = 1'b0; lock_2 = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
